// File: rtl/embedding.sv
// Embedding lookup: reads token and position rows from the shared weight store and
// builds out[i] = sat8(tok_emb[token][i] + pos_emb[pos][i]) in a DIM-lane register.

module embedding_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic       acc,
    input  logic [7:0] data,
    output logic [7:0] value
);
    logic [8:0] sum;
    logic [7:0] sat;

    assign sum = {value[7], value} + {data[7], data};
    // Overflow shows up as the two top bits of the 9-bit sum disagreeing.
    assign sat = (sum[8] != sum[7]) ? (sum[8] ? 8'h80 : 8'h7F) : sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (we)
            value <= acc ? sat : data;
    end
endmodule

module embedding #(
    parameter int DIM     = 128,
    parameter int TOK_SEL = 0,
    parameter int POS_SEL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       token_id_i,
    input  logic [7:0]       position_i,
    output logic [5:0]       w_sel_o,
    output logic [15:0]      w_addr_o,
    input  logic [7:0]       w_data_i,
    output logic [DIM*8-1:0] embed_o,
    output logic             done_o,
    output logic             busy_o
);
    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {IDLE, TOK, POS, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      pos_q;
    logic            last;
    logic [15:0]     tok_base;
    logic [15:0]     pos_base;

    logic            cap_vld;
    logic            cap_pos;
    logic [CW-1:0]   cap_idx;

    assign last     = (cnt == CW'(DIM - 1));
    assign tok_base = 16'(token_id_i) << CW;
    assign pos_base = 16'(pos_q) << CW;

    // Address/select are registered one step ahead so they line up with state/cnt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            pos_q    <= '0;
            w_sel_o  <= '0;
            w_addr_o <= '0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= TOK;
                        cnt      <= '0;
                        pos_q    <= position_i;
                        busy_o   <= 1'b1;
                        w_sel_o  <= 6'(TOK_SEL);
                        w_addr_o <= tok_base;
                    end
                end
                TOK: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state    <= POS;
                        w_sel_o  <= 6'(POS_SEL);
                        w_addr_o <= pos_base;
                    end else begin
                        w_addr_o <= w_addr_o + 16'd1;
                    end
                end
                POS: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state    <= DRAIN;
                        w_sel_o  <= '0;
                        w_addr_o <= '0;
                    end else begin
                        w_addr_o <= w_addr_o + 16'd1;
                    end
                end
                DRAIN: begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-data returns one cycle after the address; delay the lane index to match.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_vld <= 1'b0;
            cap_pos <= 1'b0;
            cap_idx <= '0;
        end else begin
            cap_vld <= (state == TOK) || (state == POS);
            cap_pos <= (state == POS);
            cap_idx <= cnt;
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        embedding_lane u_lane (
            .clk   (clk_i),
            .rst   (rst_i),
            .we    (cap_vld && (cap_idx == CW'(gi))),
            .acc   (cap_pos),
            .data  (w_data_i),
            .value (embed_o[gi*8 +: 8])
        );
    end
endmodule

// File: tb/tb_embedding.sv
// Directed bench for embedding: registered 1-cycle weight-store model, address
// sequence tracking, latency/pulse checks and a saturating-add reference.

module tb_embedding;
    localparam int DIM = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       token = '0;
    logic [7:0]       position = '0;
    logic [5:0]       w_sel;
    logic [15:0]      w_addr;
    logic [7:0]       w_data = '0;
    logic [DIM*8-1:0] embed;
    logic             done;
    logic             busy;

    logic [7:0] tok_mem [0:32767];
    logic [7:0] pos_mem [0:32767];

    int errors = 0;
    int checks = 0;

    embedding #(.DIM(DIM), .TOK_SEL(0), .POS_SEL(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .token_id_i (token),
        .position_i (position),
        .w_sel_o    (w_sel),
        .w_addr_o   (w_addr),
        .w_data_i   (w_data),
        .embed_o    (embed),
        .done_o     (done),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        w_data <= (w_sel == 6'd0) ? tok_mem[w_addr[14:0]] : pos_mem[w_addr[14:0]];

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
        return 8'(s);
    endfunction

    function automatic int lane(input int i);
        logic [7:0] v;
        v = embed[i*8 +: 8];
        return int'(v);
    endfunction

    function automatic int embed_mism(input int tok, input int pos);
        int m = 0;
        for (int i = 0; i < DIM; i++)
            if (embed[i*8 +: 8] !== sat_add(tok_mem[tok*DIM + i], pos_mem[pos*DIM + i])) m++;
        return m;
    endfunction

    function automatic int nonzero_lanes();
        int m = 0;
        for (int i = 0; i < DIM; i++)
            if (embed[i*8 +: 8] !== 8'h00) m++;
        return m;
    endfunction

    // Runs one lookup; glitch_at >= 0 pulses start that many edges into the lookup.
    task automatic run_lookup(input string tag, input int tok, input int pos, input int glitch_at);
        int n, k, amis;
        logic [15:0] ea;
        logic [5:0]  es;
        @(negedge clk);
        token = 8'(tok); position = 8'(pos); start = 1'b1;
        @(posedge clk);
        n = 0; k = 0; amis = 0;
        while (n < 4*DIM) begin
            @(negedge clk);
            start = 1'b0; token = 8'hEE; position = 8'hDD;
            if (done) break;
            if (n == glitch_at) start = 1'b1;
            if (k < DIM) begin
                es = 6'd0; ea = 16'(tok*DIM + k);
            end else if (k < 2*DIM) begin
                es = 6'd1; ea = 16'(pos*DIM + k - DIM);
            end else begin
                es = 6'd0; ea = 16'd0;
            end
            if (w_sel !== es || w_addr !== ea || busy !== 1'b1) amis++;
            k++;
            @(posedge clk);
            n++;
        end
        // start edge counted as edge 1
        check({tag, "_done_edge"}, n + 1, 2*DIM + 2);
        check({tag, "_addr_seq"}, amis, 0);
        check({tag, "_busy_in_done"}, int'(busy), 0);
        check({tag, "_embed"}, embed_mism(tok, pos), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int dones;
        for (int a = 0; a < 32768; a++) begin
            tok_mem[a] = 8'((a * 37 + 11) ^ (a >> 7));
            pos_mem[a] = 8'(a * 91 + 5);
        end

        #2 rst = 1'b1;
        #3;
        check("rst_embed", nonzero_lanes(), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(w_sel), 0);
        check("rst_addr", int'(w_addr), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_lookup("t00", 0, 0, -1);
        run_lookup("t11", 1, 1, -1);
        run_lookup("t42_10", 42, 10, -1);
        run_lookup("t255", 255, 255, -1);

        tok_mem[3*DIM + 0] = 8'h7F; pos_mem[7*DIM + 0] = 8'h01;
        tok_mem[3*DIM + 1] = 8'h80; pos_mem[7*DIM + 1] = 8'hFF;
        tok_mem[3*DIM + 2] = 8'h05; pos_mem[7*DIM + 2] = 8'hFD;
        tok_mem[3*DIM + 3] = 8'h80; pos_mem[7*DIM + 3] = 8'h80;
        tok_mem[3*DIM + 4] = 8'h7F; pos_mem[7*DIM + 4] = 8'h7F;
        run_lookup("sat", 3, 7, -1);
        check("sat_pos_clip", lane(0), 8'h7F);
        check("sat_neg_edge", lane(1), 8'h80);
        check("sat_plain", lane(2), 8'h02);
        check("sat_neg_clip", lane(3), 8'h80);
        check("sat_pos_big", lane(4), 8'h7F);

        run_lookup("busy_start", 20, 30, 50);
        dones = 0;
        repeat (2*DIM + 10) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("busy_start_no_extra_done", dones, 0);

        @(negedge clk);
        token = 8'd5; position = 8'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_embed", nonzero_lanes(), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_addr", int'(w_addr), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (2*DIM + 10) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_lookup("after_rst", 9, 4, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
